// File: rtl/ram_bus_adapter_pkg.sv
// Shared definitions for the load/store bus to byte-write RAM adapter:
// access size encodings, the pipeline stage record, and the lane
// steering / load extension helpers.
package ram_bus_adapter_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Response FIFO entry: {err, rdata}
    localparam int unsigned RSP_WIDTH = 33;

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] din;
    } lanes_t;

    // Request attributes carried to the cycle where RAM read data arrives
    typedef struct packed {
        logic       valid;
        logic       write;
        logic       err;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
    } p1_t;

    // Misaligned half/word or the reserved size encoding
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = off[0];
            SZ_WORD: err = (off != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Byte enables plus right-aligned store data replicated across all lanes
    function automatic lanes_t store_lanes(input logic [1:0]  size,
                                           input logic [1:0]  off,
                                           input logic [31:0] wdata);
        lanes_t l;
        case (size)
            SZ_BYTE: begin
                l.we  = 4'b0001 << off;
                l.din = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                l.we  = off[1] ? 4'b1100 : 4'b0011;
                l.din = {2{wdata[15:0]}};
            end
            SZ_WORD: begin
                l.we  = 4'b1111;
                l.din = wdata;
            end
            default: begin
                l.we  = 4'b0000;
                l.din = wdata;
            end
        endcase
        return l;
    endfunction

    // Select the addressed lane of a RAM word and extend it to 32 bits
    function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                                input logic        uns,
                                                input logic [1:0]  off,
                                                input logic [31:0] dout);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = dout[{off, 3'b000} +: 8];
        h = dout[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = uns ? {24'h00_0000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            SZ_WORD: r = dout;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Small synchronous FIFO holding responses until the core consumes them.
module ram_rsp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             full_s;

    // Pointer advance with wrap for any depth, not only powers of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(DEPTH - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    assign rdata  = mem_r[rd_ptr_r];
    assign count  = count_r;
    assign empty  = (count_r == '0);
    assign full_s = (count_r == CW'(DEPTH));

    // Storage array; contents are don't-care while empty, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    ram_rsp_fifo_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .full  (full_s),
        .empty (empty)
    );

endmodule

// File: rtl/ram_rsp_fifo_chk.sv
// Protocol checks for the response FIFO.
module ram_rsp_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic full,
    input logic empty
);

    // The adapter only accepts a request when a FIFO slot is reserved for it
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
        else $error("response FIFO push while full");

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty))
        else $error("response FIFO pop while empty");

endmodule

// File: rtl/ram_bus_adapter.sv
// Bridges the core load/store bus to a single-port, read-first, byte-write
// RAM with one cycle of read latency. Every accepted request produces one
// in-order response; a FIFO slot is reserved at acceptance so RAM read data
// is never dropped under response back-pressure.
module ram_bus_adapter
    import ram_bus_adapter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    input  logic [31:0]           ram_dout
);

    localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    logic                 fire_s;
    logic                 err_s;
    lanes_t               lanes_s;
    p1_t                  p1_r;
    logic                 pop_s;
    logic [OW-1:0]        occ_s;
    logic                 req_ready_s;
    logic [31:0]          push_rdata_s;
    logic [RSP_WIDTH-1:0] head_s;
    logic [CW-1:0]        count_s;
    logic                 empty_s;
    logic                 unused_addr_s;

    // Byte address bits above the RAM word range are ignored
    assign unused_addr_s = ^req_addr[31:ADDR_WIDTH+2];

    assign ram_addr  = req_addr[ADDR_WIDTH+1:2];
    assign ram_din   = lanes_s.din;
    assign req_ready = req_ready_s;

    // Acceptance counts FIFO entries, the entry in flight in P1, and a same-cycle pop
    always_comb begin
        pop_s       = ~empty_s & rsp_ready;
        occ_s       = {1'b0, count_s} + OW'(p1_r.valid) - OW'(pop_s);
        req_ready_s = (occ_s < OW'(RSP_DEPTH));
        fire_s      = req_valid & req_ready_s;
        err_s       = access_err(req_size, req_addr[1:0]);
        lanes_s     = store_lanes(req_size, req_addr[1:0], req_wdata);
        if (fire_s && req_write && !err_s) begin
            ram_we = lanes_s.we;
        end else begin
            ram_we = 4'b0000;
        end
    end

    // P1 holds the accepted request while the RAM read completes; empty otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_r <= '0;
        end else if (fire_s) begin
            p1_r <= '{valid: 1'b1,
                      write: req_write,
                      err:   err_s,
                      size:  req_size,
                      uns:   req_unsigned,
                      off:   req_addr[1:0]};
        end else begin
            p1_r <= '0;
        end
    end

    // Format RAM data for loads; stores and errors answer with zero data
    always_comb begin
        if (p1_r.write || p1_r.err) begin
            push_rdata_s = 32'h0000_0000;
        end else begin
            push_rdata_s = load_extend(p1_r.size, p1_r.uns, p1_r.off, ram_dout);
        end
    end

    ram_rsp_fifo #(
        .WIDTH (RSP_WIDTH),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (p1_r.valid),
        .wdata ({p1_r.err, push_rdata_s}),
        .pop   (pop_s),
        .rdata (head_s),
        .count (count_s),
        .empty (empty_s)
    );

    // Response outputs present the FIFO head and read as zero when empty
    always_comb begin
        rsp_valid = ~empty_s;
        if (!empty_s) begin
            rsp_err   = head_s[32];
            rsp_rdata = head_s[31:0];
        end else begin
            rsp_err   = 1'b0;
            rsp_rdata = 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_ram_bus_adapter.sv
// Directed self-checking bench for ram_bus_adapter with a read-first RAM model.
module tb_ram_bus_adapter;
    import ram_bus_adapter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic [31:0] mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_bus_adapter #(.ADDR_WIDTH(12), .RSP_DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout)
    );

    // Read-first single-port RAM, registered read data
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        end
        ram_dout <= mem[ram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic e, input logic [31:0] d);
        check({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        check({tag, "_err"},   32'(rsp_err),   32'(e));
        check({tag, "_rdata"}, rsp_rdata,      d);
    endtask

    task automatic drive(input logic v, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid    = v;
        req_write    = w;
        req_size     = sz;
        req_unsigned = u;
        req_addr     = a;
        req_wdata    = d;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    initial begin
        // Reset state
        #1;
        check_rsp("rst", 1'b0, 1'b0, 32'h0);
        check("rst_we", 32'(ram_we), 32'h0);
        check("rst_rdy", 32'(req_ready), 32'h1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;

        // 1: word store then word load
        drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        check("t1_st_we", 32'(ram_we), 32'hF);
        check("t1_st_addr", 32'(ram_addr), 32'h4);
        check("t1_st_din", ram_din, 32'hDEAD_BEEF);
        check("t1_st_rdy", 32'(req_ready), 32'h1);
        tick();
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0010, 32'h0);
        check("t1_ld_we", 32'(ram_we), 32'h0);
        check_rsp("t1_none", 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        check_rsp("t1_st_rsp", 1'b1, 1'b0, 32'h0);
        tick();
        check_rsp("t1_ld_rsp", 1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();
        check_rsp("t1_empty", 1'b0, 1'b0, 32'h0);

        // 2: byte store, signed and unsigned byte loads
        drive(1'b1, 1'b1, SZ_BYTE, 1'b0, 32'h0000_0013, 32'h0000_00A5);
        check("t2_st_we", 32'(ram_we), 32'h8);
        check("t2_st_din", ram_din, 32'hA5A5_A5A5);
        tick();
        drive(1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0013, 32'h0);
        tick();
        drive(1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h0000_0013, 32'h0);
        check_rsp("t2_st_rsp", 1'b1, 1'b0, 32'h0);
        tick();
        idle();
        check_rsp("t2_lds", 1'b1, 1'b0, 32'hFFFF_FFA5);
        tick();
        check_rsp("t2_ldu", 1'b1, 1'b0, 32'h0000_00A5);
        tick();
        check_rsp("t2_empty", 1'b0, 1'b0, 32'h0);

        // 3: half loads, misaligned half store, illegal size
        drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0000_0020, 32'h8001_1234);
        check("t3_st_we", 32'(ram_we), 32'hF);
        tick();
        drive(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h0000_0022, 32'h0);
        tick();
        drive(1'b1, 1'b1, SZ_HALF, 1'b0, 32'h0000_0021, 32'h0000_BEEF);
        check("t3_mis_we", 32'(ram_we), 32'h0);
        check_rsp("t3_st_rsp", 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b1, SZ_ILL, 1'b0, 32'h0000_0020, 32'hFFFF_FFFF);
        check("t3_ill_we", 32'(ram_we), 32'h0);
        check_rsp("t3_lhs", 1'b1, 1'b0, 32'hFFFF_8001);
        tick();
        drive(1'b1, 1'b0, SZ_HALF, 1'b1, 32'h0000_0020, 32'h0);
        check_rsp("t3_mis_rsp", 1'b1, 1'b1, 32'h0);
        tick();
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0020, 32'h0);
        check_rsp("t3_ill_rsp", 1'b1, 1'b1, 32'h0);
        tick();
        idle();
        check_rsp("t3_lhu", 1'b1, 1'b0, 32'h0000_1234);
        tick();
        check_rsp("t3_lw", 1'b1, 1'b0, 32'h8001_1234);
        tick();
        check_rsp("t3_empty", 1'b0, 1'b0, 32'h0);

        // 4: eight stores then eight back-to-back loads at full rate
        for (int c = 0; c < 19; c++) begin
            if (c < 8) drive(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0000_0100 + 32'(4 * c), pat(c));
            else if (c < 16) drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0100 + 32'(4 * (c - 8)), 32'h0);
            else idle();
            if (c < 16) check("t4_rdy", 32'(req_ready), 32'h1);
            if (c < 2 || c == 18) check_rsp("t4_none", 1'b0, 1'b0, 32'h0);
            else check_rsp("t4_rsp", 1'b1, 1'b0, (c < 10) ? 32'h0 : pat(c - 10));
            tick();
        end

        // 5: back-pressure admits exactly RSP_DEPTH requests
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0);
        check("t5_rdy0", 32'(req_ready), 32'h1);
        tick();
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0104, 32'h0);
        check("t5_rdy1", 32'(req_ready), 32'h1);
        check_rsp("t5_c1", 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0108, 32'h0);
        check("t5_rdy2", 32'(req_ready), 32'h0);
        check_rsp("t5_c2", 1'b1, 1'b0, pat(0));
        tick();
        check("t5_rdy3", 32'(req_ready), 32'h0);
        check_rsp("t5_c3", 1'b1, 1'b0, pat(0));
        tick();
        rsp_ready = 1'b1;
        #1;
        check("t5_rdy4", 32'(req_ready), 32'h1);
        check_rsp("t5_c4", 1'b1, 1'b0, pat(0));
        tick();
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_010C, 32'h0);
        check("t5_rdy5", 32'(req_ready), 32'h1);
        check_rsp("t5_c5", 1'b1, 1'b0, pat(1));
        tick();
        idle();
        check_rsp("t5_c6", 1'b1, 1'b0, pat(2));
        tick();
        check_rsp("t5_c7", 1'b1, 1'b0, pat(3));
        tick();
        check_rsp("t5_empty", 1'b0, 1'b0, 32'h0);

        // 6: asynchronous reset with P1 and one FIFO entry occupied
        rsp_ready = 1'b0;
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0100, 32'h0);
        tick();
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0104, 32'h0);
        tick();
        idle();
        check_rsp("t6_pre", 1'b1, 1'b0, pat(0));
        rst_n = 1'b0;
        #1;
        check_rsp("t6_rst", 1'b0, 1'b0, 32'h0);
        check("t6_rst_rdy", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        #1;
        check("t6_rdy", 32'(req_ready), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_rsp("t6_stale", 1'b0, 1'b0, 32'h0);
        end
        drive(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0000_0114, 32'h0);
        tick();
        idle();
        tick();
        check_rsp("t6_after", 1'b1, 1'b0, pat(5));
        tick();
        check_rsp("t6_empty", 1'b0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
